irq_aggregator: RTL and testbench



---
 rtl/irq_agg_pkg.sv | 16 +
 rtl/irq_agg_if.sv | 21 ++
 rtl/irq_agg_prio_enc.sv | 17 +
 rtl/irq_aggregator.sv | 148 ++++++++++++++
 tb/tb_irq_aggregator.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/irq_agg_pkg.sv
// irq_aggregator shared constants: register addresses and widths.
// Optional build macro IRQ_AGG_HOLDOFF_EN enables the HOLDOFF register.
package irq_agg_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int MAX_IRQ = 16;
  localparam int HIGHEST_VALID_BIT = 15;

  localparam logic [ADDR_W-1:0] ADDR_PENDING = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_MASK    = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_EDGE    = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_ACTIVE  = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_HIGHEST = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_FORCE   = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_HOLDOFF = 3'd6;
endpackage

// File: rtl/irq_agg_if.sv
// Avalon-MM slave bus bundle for irq_aggregator.
// The master modport drives address/control, the slave returns readdata.
interface irq_agg_if;
  import irq_agg_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/irq_agg_prio_enc.sv
// Lowest-index priority encoder: 16 request bits -> valid + index.
// Index is 0 when no request bit is set.
module irq_agg_prio_enc
  import irq_agg_pkg::*;
(
  input  logic [MAX_IRQ-1:0] req_i,
  output logic               valid_o,
  output logic [3:0]         idx_o
);
  always_comb begin
    valid_o = |req_i;
    idx_o   = 4'd0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = 4'(i);
    end
  end
endmodule

// File: rtl/irq_aggregator.sv
// Interrupt aggregator: per-source level/edge capture, mask, sticky pending.
// Optional build macro IRQ_AGG_HOLDOFF_EN adds an irq_out re-assert hold-off.
module irq_aggregator
  import irq_agg_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  irq_agg_if.slave           bus,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out
);
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] edge_q, edge_d;
  logic [DATA_W-1:0]  rd_q, rd_d;
  logic               irq_out_q, irq_out_d;

  logic               wr_en;
  logic               wr_pend, wr_mask, wr_edge, wr_force;
  logic [NUM_IRQ-1:0] wdata;
  logic [NUM_IRQ-1:0] rise, edge_chg, active;
  logic               any_active;
  logic               unused_wd;

  assign wr_en    = bus.chipselect & ~bus.write_n;
  assign wr_pend  = wr_en & (bus.address == ADDR_PENDING);
  assign wr_mask  = wr_en & (bus.address == ADDR_MASK);
  assign wr_edge  = wr_en & (bus.address == ADDR_EDGE);
  assign wr_force = wr_en & (bus.address == ADDR_FORCE);
  assign wdata    = bus.writedata[NUM_IRQ-1:0];
  assign unused_wd = ^bus.writedata;

  assign rise       = irq_in & ~irq_q;
  assign edge_chg   = wr_edge ? (wdata ^ edge_q) : '0;
  assign active     = pend_q & mask_q;
  assign any_active = |active;
  assign mask_d     = wr_mask ? wdata : mask_q;
  assign edge_d     = wr_edge ? wdata : edge_q;

  // Mode change wipes the bit; in edge mode a set beats a same-cycle clear.
  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_cap
    always_comb begin
      pend_d[i] = pend_q[i];
      if (edge_chg[i])
        pend_d[i] = 1'b0;
      else if (!edge_q[i])
        pend_d[i] = irq_in[i];
      else if (rise[i] || (wr_force && wdata[i]))
        pend_d[i] = 1'b1;
      else if (wr_pend && wdata[i])
        pend_d[i] = 1'b0;
    end
  end

  logic [MAX_IRQ-1:0] pend16, mask16, edge16, act16;
  logic               hi_valid;
  logic [3:0]         hi_idx;

  always_comb begin
    pend16 = '0;
    mask16 = '0;
    edge16 = '0;
    act16  = '0;
    pend16[NUM_IRQ-1:0] = pend_q;
    mask16[NUM_IRQ-1:0] = mask_q;
    edge16[NUM_IRQ-1:0] = edge_q;
    act16[NUM_IRQ-1:0]  = active;
  end

  irq_agg_prio_enc u_prio (
    .req_i   (act16),
    .valid_o (hi_valid),
    .idx_o   (hi_idx)
  );

`ifdef IRQ_AGG_HOLDOFF_EN
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              cnt_load;

  assign hold_d    = (wr_en && bus.address == ADDR_HOLDOFF)
                     ? bus.writedata : hold_q;
  assign irq_out_d = (cnt_q == '0) ? any_active : 1'b0;
  assign cnt_load  = irq_out_q & ~irq_out_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_load)
      cnt_d = hold_q;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
      cnt_q  <= '0;
    end else begin
      hold_q <= hold_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  assign irq_out_d = any_active;
`endif

  always_comb begin
    rd_d = '0;
    case (bus.address)
      ADDR_PENDING: rd_d = pend16;
      ADDR_MASK:    rd_d = mask16;
      ADDR_EDGE:    rd_d = edge16;
      ADDR_ACTIVE:  rd_d = act16;
      ADDR_HIGHEST: begin
        rd_d[HIGHEST_VALID_BIT] = hi_valid;
        rd_d[3:0]               = hi_idx;
      end
`ifdef IRQ_AGG_HOLDOFF_EN
      ADDR_HOLDOFF: rd_d = hold_q;
`endif
      default:      rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q     <= '0;
      pend_q    <= '0;
      mask_q    <= '0;
      edge_q    <= '0;
      rd_q      <= '0;
      irq_out_q <= 1'b0;
    end else begin
      irq_q     <= irq_in;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      edge_q    <= edge_d;
      rd_q      <= rd_d;
      irq_out_q <= irq_out_d;
    end
  end

  assign bus.readdata = rd_q;
  assign irq_out      = irq_out_q;
endmodule

// File: tb/tb_irq_aggregator.sv
// Directed self-checking bench for irq_aggregator (NUM_IRQ = 8).
// Define IRQ_AGG_HOLDOFF_EN to also exercise the hold-off counter.
module tb_irq_aggregator;
  import irq_agg_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [7:0] irq_in;
  logic       irq_out;
  int         errs;
  int         checks;

  irq_agg_if bus ();

  irq_aggregator #(.NUM_IRQ(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .irq_in  (irq_in),
    .irq_out (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    step();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    step();
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  logic [15:0] v;
  int          bad;
  int          k;

  initial begin
    errs = 0;
    checks = 0;
    reset_n = 1'b0;
    irq_in = '0;
    bus.address = '0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.writedata = '0;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // reset state
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      chk($sformatf("rst_rd%0d", a), v, 16'h0);
    end
    chk("rst_irq", {15'd0, irq_out}, 16'h0);

    // edge capture of a one-cycle pulse
    wr(ADDR_MASK, 16'h0001);
    wr(ADDR_EDGE, 16'h0001);
    irq_in = 8'h01;
    step();
    irq_in = 8'h00;
    chk("edge_lat1", {15'd0, irq_out}, 16'h0);
    step();
    chk("edge_lat2", {15'd0, irq_out}, 16'h1);
    rd(ADDR_PENDING, v);
    chk("edge_pend", v, 16'h0001);
    wr(ADDR_PENDING, 16'h0001);
    chk("w1c_lat1", {15'd0, irq_out}, 16'h1);
    step();
    chk("w1c_lat2", {15'd0, irq_out}, 16'h0);

    // level mode ignores W1C
    wr(ADDR_MASK, 16'h0004);
    irq_in = 8'h04;
    step();
    step();
    chk("lvl_on", {15'd0, irq_out}, 16'h1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (irq_out !== 1'b1) bad++;
    end
    wr(ADDR_PENDING, 16'h0004);
    if (irq_out !== 1'b1) bad++;
    rd(ADDR_PENDING, v);
    chk("lvl_w1c", v, 16'h0004);
    for (int i = 0; i < 3; i++) begin
      step();
      if (irq_out !== 1'b1) bad++;
    end
    chk("lvl_hold", 16'(bad), 16'h0);
    irq_in = 8'h00;
    step();
    chk("lvl_off1", {15'd0, irq_out}, 16'h1);
    step();
    chk("lvl_off2", {15'd0, irq_out}, 16'h0);

    // simultaneous rising sources, priority
    wr(ADDR_EDGE, 16'h00FF);
    wr(ADDR_MASK, 16'h00FF);
    irq_in = 8'h28;
    step();
    rd(ADDR_ACTIVE, v);
    chk("act28", v, 16'h0028);
    rd(ADDR_HIGHEST, v);
    chk("hi3", v, 16'h8003);
    wr(ADDR_PENDING, 16'h0008);
    rd(ADDR_HIGHEST, v);
    chk("hi5", v, 16'h8005);
    chk("irq_multi", {15'd0, irq_out}, 16'h1);
    irq_in = 8'h00;
    wr(ADDR_PENDING, 16'h00FF);
    rd(ADDR_PENDING, v);
    chk("clr_all", v, 16'h0000);
    rd(ADDR_HIGHEST, v);
    chk("hi_none", v, 16'h0000);

    // set beats clear; FORCE only on edge bits
    irq_in = 8'h02;
    wr(ADDR_PENDING, 16'h0002);
    rd(ADDR_PENDING, v);
    chk("set_wins", v, 16'h0002);
    irq_in = 8'h00;
    wr(ADDR_EDGE, 16'h00FD);
    rd(ADDR_PENDING, v);
    chk("mode_clr", v, 16'h0000);
    wr(ADDR_FORCE, 16'h0002);
    rd(ADDR_PENDING, v);
    chk("force_lvl", v, 16'h0000);
    wr(ADDR_FORCE, 16'h0001);
    rd(ADDR_PENDING, v);
    chk("force_edge", v, 16'h0001);
    rd(ADDR_FORCE, v);
    chk("force_rd", v, 16'h0000);
    wr(ADDR_MASK, 16'hFFFF);
    rd(ADDR_MASK, v);
    chk("mask_width", v, 16'h00FF);
    rd(3'd7, v);
    chk("rsvd7", v, 16'h0000);
    chk("irq_force", {15'd0, irq_out}, 16'h1);

`ifdef IRQ_AGG_HOLDOFF_EN
    wr(ADDR_HOLDOFF, 16'd20);
    rd(ADDR_HOLDOFF, v);
    chk("hold_rd", v, 16'd20);
    wr(ADDR_PENDING, 16'h0001);
    irq_in = 8'h01;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      irq_in = 8'h00;
      if (irq_out === 1'b1) begin
        k = i;
        break;
      end
    end
    chk("hold_cyc", 16'(k), 16'd22);
`else
    wr(ADDR_HOLDOFF, 16'h1234);
    rd(ADDR_HOLDOFF, v);
    chk("rsvd6", v, 16'h0000);
`endif

    // asynchronous reset mid-operation
    #2 reset_n = 1'b0;
    #1;
    chk("arst_irq", {15'd0, irq_out}, 16'h0);
    step();
    reset_n = 1'b1;
    rd(ADDR_MASK, v);
    chk("arst_mask", v, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
